global_avgpool_8x8_128ch: RTL and testbench
===========================================

// Module: global_avgpool_8x8_128ch
// PURPOSE
//  Downstream of the 3x3 depthwise+pointwise conv stage: 128ch x 8x8 map, 4-bit ReLU6 codes 0..6.
//  Triggers that stage, streams its output buffer through the addressed read port, one read/cycle.
//  Reduces each channel to one 8-bit mean (Q4.4) and holds 128 results in an internal result RAM.
//  The classifier head reads the result RAM.
// PARAMETERS
//  CH      128  channels; result RAM depth
//  PIX     64   pixels per channel (8x8); power of two, LOG2_PIX = $clog2(PIX)
//  DW      4    upstream activation width
//  OW      8    result width, unsigned Q4.4
//  RD_LAT  1    upstream read latency in cycles, 1..3 supported
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high reset
//  start           in   1   1-cycle pulse; accepted only in IDLE
//  image_index     in   5   image select; passed to up_image_index
//  busy            out  1   high in every state except IDLE
//  done            out  1   1-cycle pulse when all CH results are written
//  up_start        out  1   1-cycle start pulse to upstream conv stage
//  up_image_index  out  5   = image_index, combinational
//  up_done         in   1   upstream completion pulse
//  up_read_addr    out  32  registered; ch*PIX + pixel
//  up_read_data    in   DW  data for the address driven RD_LAT cycles earlier
//  res_addr        in   7   result RAM read address
//  res_data        out  OW  result RAM data, registered, 1-cycle latency
// BEHAVIOUR
//  Reset (sync): state=IDLE; busy, done, up_start = 0; up_read_addr = 0; res_data = 0; acc = 0.
//   Result RAM contents are retained, not cleared.
//  States:
//   IDLE:    start -> START_UP.
//   START_UP: up_start=1 for one cycle -> WAIT_UP.
//   WAIT_UP: holds until up_done=1 -> READ; addr counter = 0.
//   READ:    up_read_addr <= cnt; cnt++ each cycle. After cnt = CH*PIX-1 is issued -> DRAIN.
//   DRAIN:   waits RD_LAT cycles for the last data -> DONE.
//   DONE:    done=1 for one cycle -> IDLE.
//  Read pipeline:
//   - Issued address and a valid bit go through an RD_LAT-deep shift register, aligned with up_read_data.
//   - Valid is asserted only for addresses issued in READ.
//  Input clamp: d = (up_read_data > 6) ? 6 : up_read_data. d is unsigned; no sign extension.
//  Accumulator: 9-bit unsigned, max 64*6 = 384, so it never overflows.
//   - On a valid beat with addr[LOG2_PIX-1:0]==0: acc <= d (restart, no stale carry-over).
//   - Otherwise: acc <= acc + d.
//  Channel result on a valid beat with pixel==PIX-1:
//   - sum = acc + d (combinational).
//   - RAM[addr>>LOG2_PIX] <= (sum + 2) >> 2, i.e. mean*16 rounded half-up, range 0..96.
//   - Restart and the write never coincide, because PIX >= 2.
//  Timing: cycle 0 = WAIT_UP cycle that samples up_done=1.
//   - up_read_addr = k-1 in cycles k = 1..CH*PIX.
//   - done is high in cycle CH*PIX+RD_LAT+1 (8194 at defaults).
//   - busy falls in the following cycle.
//  Ignored inputs:
//   - start outside IDLE is ignored; it is not queued.
//   - up_done outside WAIT_UP is ignored.
//  Result read port:
//   - res_data <= RAM[res_addr] every cycle, independent of state.
//   - A read of the address being written in the same cycle returns the old value.
//   - Reads during a run may return results of the previous image.
//  Reset mid-run: abort immediately to IDLE and cancel in-flight reads; no further RAM writes.
//   - Channels already written keep their new values.
// TESTING
//  1. Upstream model returns 6 everywhere; start -> done at cycle 8194 after up_done; res[0..127] = 96.
//  2. Pixel value = p%7 (p = 0..63), all channels -> sum 189, every res = 47; channel c = const c%7 -> res = 16*(c%7).
//  3. Value 15 injected at ch5 px0, others 0 -> clamped to 6, sum 6, res[5] = 2; res[4] = res[6] = 0.
//  4. Address checks:
//     - up_read_addr sequence 0..8191 with no gaps or repeats.
//     - Repeat test 1 with RD_LAT=2 -> results unchanged, done at 8195.
//  5. start pulsed in READ and in DONE -> no extra up_start, single done pulse.
//     Two back-to-back runs with different data -> second result set overwrites the first.
//  6. reset at up_read_addr=1000:
//     - Next cycle busy=0, done=0, res_data=0.
//     - New start completes with correct results per test 1.

Source files
------------

// File: rtl/global_avgpool_8x8_128ch.sv
// Global average pool over a 128ch x 8x8 map of 4-bit ReLU6 codes.
// Triggers the conv stage, streams its buffer, keeps one Q4.4 mean per channel.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           1-cycle run request, taken only when idle
//   image_index     image select, forwarded as up_image_index
//   busy, done      run in progress; 1-cycle completion pulse
//   up_start        1-cycle trigger to the conv stage
//   up_done         conv stage completion pulse
//   up_read_addr    registered read address, ch*PIX + pixel
//   up_read_data    data for the address issued RD_LAT cycles earlier
//   res_addr        result RAM read address
//   res_data        result RAM data, 1-cycle latency
module global_avgpool_8x8_128ch #(
  parameter int CH     = 128,
  parameter int PIX    = 64,
  parameter int DW     = 4,
  parameter int OW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            image_index,
  output logic                  busy,
  output logic                  done,
  output logic                  up_start,
  output logic [4:0]            up_image_index,
  input  logic                  up_done,
  output logic [31:0]           up_read_addr,
  input  logic [DW-1:0]         up_read_data,
  input  logic [$clog2(CH)-1:0] res_addr,
  output logic [OW-1:0]         res_data
);

  localparam int LOG2_PIX = $clog2(PIX);
  localparam int TOT      = CH * PIX;
  localparam int AW       = $clog2(TOT);
  localparam int CW       = $clog2(CH);
  localparam int ACCW     = $clog2(PIX * 6 + 1);

  typedef enum logic [2:0] {
    IDLE,
    START_UP,
    WAIT_UP,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [1:0]      dcnt;
  logic [AW-1:0]   pa [RD_LAT];
  logic [RD_LAT-1:0] pv;
  logic [ACCW-1:0] acc;
  logic [OW-1:0]   ram [CH];

  logic                beat_v;
  logic [AW-1:0]       beat_a;
  logic [LOG2_PIX-1:0] pix;
  logic [CW-1:0]       ch;
  logic [DW-1:0]       d;
  logic [ACCW-1:0]     sum;
  logic [ACCW:0]       rnd;
  logic [OW-1:0]       mean;

  assign up_image_index = image_index;
  assign up_read_addr   = 32'(cnt);

  // Oldest pipeline slot lines up with up_read_data.
  assign beat_v = pv[RD_LAT-1];
  assign beat_a = pa[RD_LAT-1];
  assign pix    = beat_a[LOG2_PIX-1:0];
  assign ch     = beat_a[AW-1:LOG2_PIX];

  assign d    = (up_read_data > DW'(6)) ? DW'(6) : up_read_data;
  assign sum  = acc + ACCW'(d);
  // mean*16 = sum*16/64 = sum/4, rounded half-up.
  assign rnd  = {1'b0, sum} + (ACCW + 1)'(2);
  assign mean = OW'(rnd >> 2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      up_start <= 1'b0;
      cnt      <= '0;
      dcnt     <= '0;
    end else begin
      up_start <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= START_UP;
            busy     <= 1'b1;
            up_start <= 1'b1;
          end
        end
        START_UP: state <= WAIT_UP;
        WAIT_UP: begin
          if (up_done) begin
            state <= READ;
            cnt   <= '0;
          end
        end
        READ: begin
          if (cnt == AW'(TOT - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == 2'(RD_LAT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset clears the valid bits, cancelling reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pa[i] <= '0;
    end else begin
      pv[0] <= (state == READ);
      pa[0] <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (beat_v) begin
      acc <= (pix == '0) ? ACCW'(d) : sum;
    end
  end

  // Contents survive reset; only a live beat writes.
  always_ff @(posedge clk) begin
    if (!reset && beat_v && pix == LOG2_PIX'(PIX - 1)) begin
      ram[ch] <= mean;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_data <= '0;
    end else begin
      res_data <= ram[res_addr];
    end
  end

endmodule

// File: tb/tb_global_avgpool_8x8_128ch.sv
// Scoreboard bench for global_avgpool_8x8_128ch.
// Two instances (RD_LAT 1 and 2) run in lockstep on one upstream image.
module tb_global_avgpool_8x8_128ch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       up_done;
  logic [4:0] image_index;
  logic [6:0] res_addr;

  logic        busy_a, done_a, up_start_a;
  logic        busy_b, done_b, up_start_b;
  logic [4:0]  uii_a, uii_b;
  logic [31:0] ura_a, ura_b;
  logic [3:0]  urd_a, urd_b;
  logic [7:0]  res_a, res_b;

  global_avgpool_8x8_128ch #(.RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .image_index(image_index), .busy(busy_a), .done(done_a),
    .up_start(up_start_a), .up_image_index(uii_a),
    .up_done(up_done), .up_read_addr(ura_a),
    .up_read_data(urd_a), .res_addr(res_addr), .res_data(res_a)
  );

  global_avgpool_8x8_128ch #(.RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .image_index(image_index), .busy(busy_b), .done(done_b),
    .up_start(up_start_b), .up_image_index(uii_b),
    .up_done(up_done), .up_read_addr(ura_b),
    .up_read_data(urd_b), .res_addr(res_addr), .res_data(res_b)
  );

  // Upstream buffer model with 1- and 2-cycle read latency.
  logic [3:0] mem [8192];
  logic [3:0] a_d1, b_d1, b_d2;
  always @(posedge clk) begin
    a_d1 <= mem[ura_a[12:0]];
    b_d1 <= mem[ura_b[12:0]];
    b_d2 <= b_d1;
  end
  assign urd_a = a_d1;
  assign urd_b = b_d2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Result scoreboard: driver pushes, monitor pops one cycle later.
  logic [7:0] q [$];
  logic       req, req_d;
  logic [7:0] sb_e;
  always @(posedge clk) req_d <= req;
  always @(negedge clk) begin
    if (req_d) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(q.size()), 32'(1));
      end else begin
        sb_e = q.pop_front();
        chk("res_a", 32'(res_a), 32'(sb_e));
        chk("res_b", 32'(res_b), 32'(sb_e));
      end
    end
  end

  // Mean of clamped codes, in sixteenths, rounded half-up.
  task automatic read_results();
    for (int c = 0; c < 128; c++) begin
      int s;
      s = 0;
      for (int p = 0; p < 64; p++) begin
        int v;
        v = int'(mem[c*64 + p]);
        s += (v > 6) ? 6 : v;
      end
      @(negedge clk);
      q.push_back(8'((s * 16 + 32) / 64));
      res_addr = 7'(c);
      req = 1'b1;
    end
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(q.size()), 32'(0));
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 8192; i++) begin
      case (mode)
        0: mem[i] = 4'd6;
        1: mem[i] = 4'((i % 64) % 7);
        2: mem[i] = 4'((i / 64) % 7);
        3: mem[i] = (i == 5*64) ? 4'd15 : 4'd0;
        default: mem[i] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  // Start, answer up_start, then raise up_done (cleared by caller).
  task automatic kick();
    int n;
    @(negedge clk);
    start = 1'b1;
    image_index = 5'($urandom);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!up_start_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("up_start_a", 32'(up_start_a), 32'(1));
    chk("up_start_b", 32'(up_start_b), 32'(1));
    chk("img_idx", 32'(uii_a), 32'(image_index));
    repeat ($urandom_range(1, 6)) @(negedge clk);
    chk("busy_wait", 32'(busy_a), 32'(1));
    up_done = 1'b1;
  endtask

  task automatic run(input bit poke);
    int k, ta, tb, nda, ndb, nus, bad_a, bad_b;
    kick();
    k = 0; ta = 0; tb = 0; nda = 0; ndb = 0;
    nus = 0; bad_a = 0; bad_b = 0;
    while (k < 8300 && !(tb != 0 && k > tb + 1)) begin
      @(negedge clk);
      k++;
      if (k == 1) up_done = 1'b0;
      if (k <= 8192) begin
        if (ura_a !== 32'(k - 1)) bad_a++;
        if (ura_b !== 32'(k - 1)) bad_b++;
      end
      if (ta != 0 && k == ta + 1)
        chk("busy_fall_a", 32'(busy_a), 32'(0));
      if (tb != 0 && k == tb + 1)
        chk("busy_fall_b", 32'(busy_b), 32'(0));
      if (done_a) begin nda++; ta = k; end
      if (done_b) begin ndb++; tb = k; end
      if (up_start_a || up_start_b) nus++;
      if (poke) start = (k == 500 || k == 8194);
    end
    start = 1'b0;
    chk("done_cyc_a", 32'(ta), 32'(8194));
    chk("done_cyc_b", 32'(tb), 32'(8195));
    chk("done_cnt_a", 32'(nda), 32'(1));
    chk("done_cnt_b", 32'(ndb), 32'(1));
    chk("extra_up_start", 32'(nus), 32'(0));
    chk("addr_seq_a", 32'(bad_a), 32'(0));
    chk("addr_seq_b", 32'(bad_b), 32'(0));
    repeat (2) @(negedge clk);
    chk("idle_busy_a", 32'(busy_a), 32'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; up_done = 1'b0;
    image_index = '0; res_addr = '0; req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_up_start", 32'(up_start_a), 32'(0));
    chk("rst_addr", ura_a, 32'(0));
    chk("rst_res", 32'(res_a), 32'(0));
    chk("rst_res_b", 32'(res_b), 32'(0));
    reset = 1'b0;

    // Stray up_done while idle must not start anything.
    @(negedge clk);
    up_done = 1'b1;
    @(negedge clk);
    up_done = 1'b0;
    @(negedge clk);
    chk("idle_up_done", 32'(busy_a), 32'(0));

    fill(0); run(1'b0); read_results();
    fill(1); run(1'b0); read_results();
    fill(2); run(1'b0); read_results();
    fill(3); run(1'b0); read_results();
    fill(4); run(1'b1);
    fill(4); run(1'b1); read_results();

    // Abort mid-stream.
    fill(4);
    kick();
    n = 0;
    @(negedge clk);
    up_done = 1'b0;
    while (ura_a !== 32'd1000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_1000", ura_a, 32'd1000);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy_a", 32'(busy_a), 32'(0));
    chk("abort_busy_b", 32'(busy_b), 32'(0));
    chk("abort_done", 32'(done_a), 32'(0));
    chk("abort_res_a", 32'(res_a), 32'(0));
    chk("abort_res_b", 32'(res_b), 32'(0));
    chk("abort_addr", ura_a, 32'(0));
    reset = 1'b0;
    fill(0); run(1'b0); read_results();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
